// File: rtl/spi_host_tx_seq.sv
// SPI host transaction sequencer: sends a command byte MSB first on mosi and can then
// open an 8-bit rcv_start window that lets the downstream receive shifter capture a reply.
module spi_host_tx_seq #(
  parameter int unsigned DIV_HALF = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  input  logic       rsp_expect,
  output logic       cmd_ready,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  output logic       rcv_start,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, SETUP, TX, RX, HOLD} state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV_HALF - 1);

  state_t     state, state_d;
  logic [7:0] div_cnt, div_cnt_d;
  logic [7:0] shreg, shreg_d;
  logic       rsp_q, rsp_q_d;
  logic [3:0] bit_cnt, bit_cnt_d;
  logic       sclk_d, cs_n_d, mosi_d, rcv_start_d, done_d;
  logic       tick;

  assign tick      = (div_cnt == DIV_LAST);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // State and all outputs are registered so sclk/cs_n/mosi never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      shreg     <= '0;
      rsp_q     <= 1'b0;
      bit_cnt   <= '0;
      sclk      <= 1'b0;
      cs_n      <= 1'b1;
      mosi      <= 1'b0;
      rcv_start <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      div_cnt   <= div_cnt_d;
      shreg     <= shreg_d;
      rsp_q     <= rsp_q_d;
      bit_cnt   <= bit_cnt_d;
      sclk      <= sclk_d;
      cs_n      <= cs_n_d;
      mosi      <= mosi_d;
      rcv_start <= rcv_start_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    rsp_q_d     = rsp_q;
    bit_cnt_d   = bit_cnt;
    sclk_d      = sclk;
    cs_n_d      = cs_n;
    mosi_d      = mosi;
    rcv_start_d = rcv_start;
    done_d      = 1'b0;
    if (state == IDLE || tick) div_cnt_d = '0;
    else                       div_cnt_d = div_cnt + 8'd1;

    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          shreg_d   = cmd_data;
          rsp_q_d   = rsp_expect;
          cs_n_d    = 1'b0;
          mosi_d    = cmd_data[7];
          bit_cnt_d = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (tick) state_d = TX;
      end
      TX: begin
        if (tick) begin
          if (!sclk) begin
            sclk_d = 1'b1;
            // Bit 7 is already on mosi from acceptance; later rising edges advance the byte.
            if (bit_cnt != 4'd0) begin
              shreg_d = {shreg[6:0], 1'b0};
              mosi_d  = shreg[6];
            end
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_d = '0;
              mosi_d    = 1'b0;
              if (rsp_q) begin
                rcv_start_d = 1'b1;
                state_d     = RX;
              end else begin
                state_d = HOLD;
              end
            end
          end
        end
      end
      RX: begin
        if (tick) begin
          if (!sclk) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_d   = '0;
              rcv_start_d = 1'b0;
              state_d     = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_host_tx_seq.sv
// Directed bench for spi_host_tx_seq: one instance at DIV_HALF=2 and one at DIV_HALF=1,
// with a small slave/receive-shifter model driven from sampled sclk edges.
module tb_spi_host_tx_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       rsp_expect;

  logic a_valid, a_ready, a_sclk, a_cs_n, a_mosi, a_rcv, a_busy, a_done;
  logic b_valid, b_ready, b_sclk, b_cs_n, b_mosi, b_rcv, b_busy, b_done;
  logic m_ready, m_sclk, m_cs_n, m_mosi, m_rcv, m_busy, m_done;

  int checks = 0;
  int errors = 0;

  int         cs_low, rises, falls, sclk_hi, rcv_hi, rises_at_rcv;
  int         ready_err, busy_err, mosi_rx_err, mosi_late;
  logic       timed_out;
  logic [7:0] mosi_word, rsps, slave_byte;

  always #5 clk = ~clk;

  assign a_valid = cmd_valid & ~sel;
  assign b_valid = cmd_valid & sel;
  assign m_ready = sel ? b_ready : a_ready;
  assign m_sclk  = sel ? b_sclk  : a_sclk;
  assign m_cs_n  = sel ? b_cs_n  : a_cs_n;
  assign m_mosi  = sel ? b_mosi  : a_mosi;
  assign m_rcv   = sel ? b_rcv   : a_rcv;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;

  spi_host_tx_seq #(.DIV_HALF(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(a_valid), .cmd_data(cmd_data),
    .rsp_expect(rsp_expect), .cmd_ready(a_ready), .sclk(a_sclk), .cs_n(a_cs_n),
    .mosi(a_mosi), .rcv_start(a_rcv), .busy(a_busy), .done(a_done)
  );

  spi_host_tx_seq #(.DIV_HALF(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_data(cmd_data),
    .rsp_expect(rsp_expect), .cmd_ready(b_ready), .sclk(b_sclk), .cs_n(b_cs_n),
    .mosi(b_mosi), .rcv_start(b_rcv), .busy(b_busy), .done(b_done)
  );

  // Samples the selected DUT every falling clk edge until done; the slave changes miso on
  // sclk falls starting with the last command fall, the receiver samples on falls under rcv_start.
  task automatic capture();
    logic prev_sclk, prev_rcv, miso;
    cs_low = 0; rises = 0; falls = 0; sclk_hi = 0; rcv_hi = 0; rises_at_rcv = -1;
    ready_err = 0; busy_err = 0; mosi_rx_err = 0; mosi_late = 0; timed_out = 1'b0;
    mosi_word = '0; rsps = '0;
    prev_sclk = 1'b0; prev_rcv = 1'b0;
    for (int cyc = 0; ; cyc++) begin
      if (cyc == 2000) begin
        timed_out = 1'b1;
        break;
      end
      if (prev_sclk && !m_sclk) begin
        miso = (falls >= 8 && falls < 16) ? slave_byte[7 - (falls - 8)] : 1'b0;
        if (prev_rcv) rsps = {rsps[6:0], miso};
        falls++;
      end
      if (!prev_sclk && m_sclk) begin
        rises++;
        if (rises <= 8) mosi_word = {mosi_word[6:0], m_mosi};
      end
      if (!m_cs_n) cs_low++;
      if (m_sclk) sclk_hi++;
      if (m_rcv) begin
        rcv_hi++;
        if (rises_at_rcv < 0) rises_at_rcv = rises;
      end
      if (!m_cs_n && m_ready) ready_err++;
      if (m_busy !== !m_cs_n) busy_err++;
      if (falls >= 8 && m_mosi) mosi_rx_err++;
      if (rises >= 2 && m_mosi) mosi_late++;
      if (m_done) break;
      prev_sclk = m_sclk;
      prev_rcv  = m_rcv;
      @(negedge clk);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] cmd, input logic rsp, input logic [7:0] slave,
                                input logic scramble);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = cmd; rsp_expect = rsp; slave_byte = slave;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (scramble) begin
      cmd_data   = ~cmd;
      rsp_expect = ~rsp;
    end
    capture();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel = 1'b0; cmd_valid = 1'b0; cmd_data = '0; rsp_expect = 1'b0; slave_byte = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_cs_n, a_sclk, a_mosi, a_rcv, a_done, a_ready, a_busy} !== 7'b1000010) begin
      errors++;
      $display("[TB] FAIL reset_a: got %b expected 1000010",
               {a_cs_n, a_sclk, a_mosi, a_rcv, a_done, a_ready, a_busy});
    end
    checks++;
    if ({b_cs_n, b_sclk, b_mosi, b_rcv, b_done, b_ready, b_busy} !== 7'b1000010) begin
      errors++;
      $display("[TB] FAIL reset_b: got %b expected 1000010",
               {b_cs_n, b_sclk, b_mosi, b_rcv, b_done, b_ready, b_busy});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_cmd_no_rsp();
    sel = 1'b0;
    apply_stimulus(8'hA5, 1'b0, 8'h00, 1'b0);
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL a5_timeout: no done seen"); end
    checks++;
    if (mosi_word !== 8'hA5) begin errors++; $display("[TB] FAIL a5_mosi: got %h expected a5", mosi_word); end
    checks++;
    if (rises != 8) begin errors++; $display("[TB] FAIL a5_pulses: got %0d expected 8", rises); end
    checks++;
    if (cs_low != 36) begin errors++; $display("[TB] FAIL a5_cs_low: got %0d expected 36", cs_low); end
    checks++;
    if (rcv_hi != 0) begin errors++; $display("[TB] FAIL a5_rcv: got %0d expected 0", rcv_hi); end
    checks++;
    if (ready_err != 0 || busy_err != 0) begin
      errors++;
      $display("[TB] FAIL a5_ready_busy: got %0d/%0d expected 0/0", ready_err, busy_err);
    end
    @(negedge clk);
    checks++;
    if (m_done !== 1'b0) begin errors++; $display("[TB] FAIL a5_done_width: got %b expected 0", m_done); end
  endtask

  task automatic test_cmd_rsp();
    sel = 1'b0;
    apply_stimulus(8'h3C, 1'b1, 8'h96, 1'b0);
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL 3c_timeout: no done seen"); end
    checks++;
    if (mosi_word !== 8'h3C) begin errors++; $display("[TB] FAIL 3c_mosi: got %h expected 3c", mosi_word); end
    checks++;
    if (rises != 16 || sclk_hi != 32) begin
      errors++;
      $display("[TB] FAIL 3c_sclk: got %0d pulses %0d high clks expected 16 32", rises, sclk_hi);
    end
    checks++;
    if (cs_low != 68) begin errors++; $display("[TB] FAIL 3c_cs_low: got %0d expected 68", cs_low); end
    checks++;
    if (rcv_hi != 32 || rises_at_rcv != 8) begin
      errors++;
      $display("[TB] FAIL 3c_rcv_window: got %0d clks after %0d pulses expected 32 after 8",
               rcv_hi, rises_at_rcv);
    end
    checks++;
    if (rsps !== 8'h96) begin errors++; $display("[TB] FAIL 3c_rsps: got %h expected 96", rsps); end
    checks++;
    if (mosi_rx_err != 0) begin errors++; $display("[TB] FAIL 3c_mosi_rx: got %0d expected 0", mosi_rx_err); end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 8'h01; rsp_expect = 1'b0; slave_byte = 8'h00;
    @(negedge clk);
    cmd_data = 8'hFF;
    capture();
    checks++;
    if (timed_out !== 1'b0 || mosi_word !== 8'h01) begin
      errors++;
      $display("[TB] FAIL b2b_first: got %h timeout %b expected 01 timeout 0", mosi_word, timed_out);
    end
    checks++;
    if (ready_err != 0) begin errors++; $display("[TB] FAIL b2b_ready_low: got %0d expected 0", ready_err); end
    checks++;
    if (m_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_at_done: got %b expected 1", m_ready); end
    @(negedge clk);
    checks++;
    if ({m_cs_n, m_busy, m_done} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL b2b_accept: got %b expected 010", {m_cs_n, m_busy, m_done});
    end
    cmd_valid = 1'b0;
    capture();
    checks++;
    if (mosi_word !== 8'hFF || cs_low != 36) begin
      errors++;
      $display("[TB] FAIL b2b_second: got %h cs_low %0d expected ff 36", mosi_word, cs_low);
    end
  endtask

  task automatic test_reset_mid_tx();
    int   nf;
    int   cyc;
    logic prev;
    sel = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = 8'hC3; rsp_expect = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    nf = 0; cyc = 0; prev = a_sclk;
    while (nf < 3 && cyc < 500) begin
      @(negedge clk);
      if (prev && !a_sclk) nf++;
      prev = a_sclk;
      cyc++;
    end
    checks++;
    if (nf != 3) begin errors++; $display("[TB] FAIL rst_reach_fall3: got %0d falls expected 3", nf); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_cs_n, a_sclk, a_rcv, a_busy, a_ready, a_mosi} !== 6'b100010) begin
      errors++;
      $display("[TB] FAIL rst_async: got %b expected 100010", {a_cs_n, a_sclk, a_rcv, a_busy, a_ready, a_mosi});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nf = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_done !== 1'b0 || a_cs_n !== 1'b1) nf++;
    end
    checks++;
    if (nf != 0) begin errors++; $display("[TB] FAIL rst_no_done: got %0d bad clks expected 0", nf); end
    apply_stimulus(8'h55, 1'b0, 8'h00, 1'b0);
    checks++;
    if (mosi_word !== 8'h55 || rises != 8 || cs_low != 36) begin
      errors++;
      $display("[TB] FAIL rst_next_cmd: got %h %0d %0d expected 55 8 36", mosi_word, rises, cs_low);
    end
  endtask

  task automatic test_div1();
    sel = 1'b1;
    apply_stimulus(8'h80, 1'b1, 8'h5A, 1'b0);
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL div1_timeout: no done seen"); end
    checks++;
    if (rises != 16 || sclk_hi != 16) begin
      errors++;
      $display("[TB] FAIL div1_sclk: got %0d pulses %0d high clks expected 16 16", rises, sclk_hi);
    end
    checks++;
    if (cs_low != 34) begin errors++; $display("[TB] FAIL div1_cs_low: got %0d expected 34", cs_low); end
    checks++;
    if (mosi_word !== 8'h80 || mosi_late != 0) begin
      errors++;
      $display("[TB] FAIL div1_mosi: got %h late %0d expected 80 0", mosi_word, mosi_late);
    end
    checks++;
    if (rcv_hi != 16 || rsps !== 8'h5A) begin
      errors++;
      $display("[TB] FAIL div1_rsp: got %0d clks rsps %h expected 16 5a", rcv_hi, rsps);
    end
    sel = 1'b0;
  endtask

  task automatic test_cmd_change();
    sel = 1'b0;
    apply_stimulus(8'h69, 1'b0, 8'h00, 1'b1);
    checks++;
    if (mosi_word !== 8'h69 || rises != 8) begin
      errors++;
      $display("[TB] FAIL cmd_change: got %h %0d pulses expected 69 8", mosi_word, rises);
    end
  endtask

  initial begin
    test_reset();
    test_cmd_no_rsp();
    test_cmd_rsp();
    test_back_to_back();
    test_reset_mid_tx();
    test_div1();
    test_cmd_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
